psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
- Shares one PsramController between two requesters (port A, port B), e.g. CPU and video/DMA.
- Converts each requester's level request/ack handshake into the controller's one-cycle read/write pulse, busy-tracked protocol.
- Sits between the requesters and the PsramController, all in the PSRAM clock domain.
- Arbitration is round-robin, or fixed priority to port A; includes a per-transaction timeout.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between A and B; 1 = A always wins a simultaneous request.
- TIMEOUT, 31: max cycles in WAIT before forcing ack with error; counter is 6 bits wide, legal range 2..63.

Ports:
- clk  in  1  PSRAM controller clock (same clk that drives PsramController).
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held high with a_we/a_byte/a_addr/a_wdata stable until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_byte  in  1  byte write (selects the byte lane by a_addr[0]).
- a_addr  in  22  byte address.
- a_wdata  in  16  write data.
- a_rdata  out  16  read data, valid in the a_ack cycle.
- a_ack  out  1  one-cycle completion pulse.
- a_err  out  1  valid with a_ack; 1 = timed out.
- b_req, b_we, b_byte, b_addr, b_wdata, b_rdata, b_ack, b_err: same as port A, for port B.
- mem_read  out  1  one-cycle read pulse to the controller.
- mem_write  out  1  one-cycle write pulse to the controller.
- mem_byte_write  out  1  byte-write qualifier.
- mem_addr  out  22  address to the controller.
- mem_din  out  16  write data to the controller.
- mem_dout  in  16  read data from the controller.
- mem_busy  in  1  controller busy.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, last_grant=B (so A wins first), counter=0. All outputs 0: mem_read, mem_write, mem_byte_write, mem_addr, mem_din, a_ack, b_ack, a_err, b_err, a_rdata, b_rdata.
- Reset mid-transaction: abandon it with no ack. Controller may still be busy; IDLE waits for mem_busy=0 before issuing again.
- State IDLE:
  - Grant only if mem_busy=0 and at least one req is high.
  - Only one request: grant it.
  - Both requests, FIXED_PRIO=0: grant the port opposite last_grant.
  - Both requests, FIXED_PRIO=1: grant A.
  - On grant: latch port fields into mem_addr/mem_din/mem_byte_write and a write flag, set last_grant, go to ISSUE.
- State ISSUE (1 cycle):
  - Assert mem_write (write flag=1) or mem_read (write flag=0) for exactly this cycle.
  - Clear counter; go to WAIT.
- State WAIT:
  - Counter increments each cycle.
  - mem_busy is ignored in the first WAIT cycle (controller raises busy one cycle after the pulse).
  - From the second cycle, mem_busy=0: go to DONE.
  - Counter==TIMEOUT: set err; go to DONE.
- State DONE (1 cycle):
  - Granted port's ack=1 and err = timeout flag.
  - Read: rdata <= mem_dout.
  - Write: rdata holds its previous value.
  - Go to IDLE.
- Timing:
  - Minimum req-to-ack latency = 4 cycles (IDLE, ISSUE, 2 WAIT) plus controller busy time.
  - Back-to-back: at most one transaction completes per DONE.
  - A requester may re-assert req the cycle after ack; it is eligible in the next IDLE.
- A req that drops before ack is a protocol error. Behaviour is undefined, but the FSM must still return to IDLE.
- mem_addr, mem_din and mem_byte_write hold their latched values outside ISSUE.
- Starvation bound: with round-robin, a waiting port is served within one transaction of the other port.

Optional Feature:
- Macro PSRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_a_cnt [23:0], stat_b_cnt [23:0], stat_timeout_cnt [15:0], stat_max_wait [7:0].
  - stat_a_cnt and stat_b_cnt count acks per port; stat_timeout_cnt counts err acks.
  - stat_max_wait is the largest WAIT counter value seen.
  - All counters are cleared by reset and saturate (no wrap).
- Undefined: these ports and their logic are absent. Functional behaviour is identical.

Test Plan:
- A write 0x1234 to addr 0x000010 (controller model busy 6 cycles), then A read addr 0x000010 -> each gets exactly one a_ack; read a_rdata=0x1234; a_err=0; b_ack never asserted.
- A and B both held requesting, FIXED_PRIO=0, 6 transactions total -> grant order A,B,A,B,A,B; exactly one mem_read/mem_write pulse per grant.
- Same stimulus with FIXED_PRIO=1 and A re-requesting immediately after each ack -> A served continuously; B acked only after A stops requesting.
- Controller model never drops busy, TIMEOUT=31 -> ack with err=1 exactly 31 cycles after entering WAIT. Next request issues only after model busy=0.
- Reset asserted during WAIT, model still busy 5 more cycles -> no ack; outputs 0; first new mem_read issued only after mem_busy=0.
- PSRAM_ARB_STATS_EN defined, 3 A ops + 2 B ops + 1 timeout -> stat_a_cnt and stat_b_cnt match the per-port ack counts; stat_timeout_cnt=1; stat_max_wait=31.

Source files
------------

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - two-port arbiter sharing one PSRAM controller
//
// Purpose: turns two level req/ack requesters (A, B) into the controller's
// one-cycle read/write pulse + busy protocol. Round-robin or fixed A priority,
// with a per-transaction busy timeout that acks with an error.
// Ports:
//   clk, reset             controller clock, synchronous active-high reset
//   a_*/b_*                requester ports: req/we/byte/addr/wdata in,
//                          rdata/ack/err out (ack is a one-cycle pulse)
//   mem_read/mem_write     one-cycle command pulses to the controller
//   mem_byte_write, mem_addr, mem_din   latched command fields
//   mem_dout, mem_busy     controller read data and busy
// Optional: define PSRAM_ARB_STATS_EN to add stat_a_cnt, stat_b_cnt,
//   stat_timeout_cnt and stat_max_wait (saturating, cleared by reset).
module psram_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_byte,
  input  logic [21:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic [15:0] a_rdata,
  output logic        a_ack,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_byte,
  input  logic [21:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_rdata,
  output logic        b_ack,
  output logic        b_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy
`ifdef PSRAM_ARB_STATS_EN
  ,
  output logic [23:0] stat_a_cnt,
  output logic [23:0] stat_b_cnt,
  output logic [15:0] stat_timeout_cnt,
  output logic [7:0]  stat_max_wait
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);

  state_t      state_q;
  logic        last_b_q;   // 1 = port B held the most recent grant
  logic        sel_b_q;    // port owning the transaction in flight
  logic        we_q;
  logic [5:0]  cnt_q;
  logic        mem_read_q, mem_write_q, mem_byte_q;
  logic [21:0] mem_addr_q;
  logic [15:0] mem_din_q;
  logic [15:0] a_rdata_q, b_rdata_q;
  logic        a_ack_q, b_ack_q, a_err_q, b_err_q;

  logic        grant_b_d;
  logic [5:0]  cnt_d;
  logic        busy_done_d, timeout_d;

  always_comb begin
    grant_b_d = b_req;
    if (a_req && b_req) begin
      grant_b_d = (FIXED_PRIO == 0) ? !last_b_q : 1'b0;
    end
  end

  assign cnt_d = cnt_q + 6'd1;
  // Busy is only meaningful from the second WAIT cycle: the controller
  // raises it one cycle after the command pulse.
  assign busy_done_d = (cnt_q != 6'd0) && !mem_busy;
  assign timeout_d   = !busy_done_d && (cnt_d == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_b_q    <= 1'b1;
      sel_b_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 6'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= 22'd0;
      mem_din_q   <= 16'd0;
      a_rdata_q   <= 16'd0;
      b_rdata_q   <= 16'd0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!mem_busy && (a_req || b_req)) begin
            sel_b_q    <= grant_b_d;
            last_b_q   <= grant_b_d;
            we_q       <= grant_b_d ? b_we    : a_we;
            mem_byte_q <= grant_b_d ? b_byte  : a_byte;
            mem_addr_q <= grant_b_d ? b_addr  : a_addr;
            mem_din_q  <= grant_b_d ? b_wdata : a_wdata;
            // Pulse registered here so it is high for the ISSUE cycle only.
            mem_write_q <= grant_b_d ? b_we  : a_we;
            mem_read_q  <= grant_b_d ? !b_we : !a_we;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= 6'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (busy_done_d || timeout_d) begin
            // Ack/err/rdata are registered so they are valid during DONE.
            if (sel_b_q) begin
              b_ack_q <= 1'b1;
              b_err_q <= timeout_d;
              if (!we_q) b_rdata_q <= mem_dout;
            end else begin
              a_ack_q <= 1'b1;
              a_err_q <= timeout_d;
              if (!we_q) a_rdata_q <= mem_dout;
            end
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_byte_write = mem_byte_q;
  assign mem_addr       = mem_addr_q;
  assign mem_din        = mem_din_q;
  assign a_rdata        = a_rdata_q;
  assign b_rdata        = b_rdata_q;
  assign a_ack          = a_ack_q;
  assign b_ack          = b_ack_q;
  assign a_err          = a_err_q;
  assign b_err          = b_err_q;

`ifdef PSRAM_ARB_STATS_EN
  logic [23:0] stat_a_q, stat_b_q;
  logic [15:0] stat_to_q;
  logic [7:0]  stat_max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_a_q   <= 24'd0;
      stat_b_q   <= 24'd0;
      stat_to_q  <= 16'd0;
      stat_max_q <= 8'd0;
    end else begin
      if (a_ack_q && (stat_a_q != 24'hFFFFFF)) stat_a_q <= stat_a_q + 24'd1;
      if (b_ack_q && (stat_b_q != 24'hFFFFFF)) stat_b_q <= stat_b_q + 24'd1;
      if ((a_err_q || b_err_q) && (stat_to_q != 16'hFFFF)) stat_to_q <= stat_to_q + 16'd1;
      if ((state_q == S_WAIT) && ({2'b00, cnt_d} > stat_max_q)) stat_max_q <= {2'b00, cnt_d};
    end
  end

  assign stat_a_cnt       = stat_a_q;
  assign stat_b_cnt       = stat_b_q;
  assign stat_timeout_cnt = stat_to_q;
  assign stat_max_wait    = stat_max_q;
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - self-checking bench for psram_arbiter
module tb_psram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic        rst [2];
  logic        a_req [2], a_we [2], a_byte [2], b_req [2], b_we [2], b_byte [2];
  logic [21:0] a_addr [2], b_addr [2], mem_addr [2];
  logic [15:0] a_wdata [2], b_wdata [2], a_rdata [2], b_rdata [2];
  logic        a_ack [2], a_err [2], b_ack [2], b_err [2];
  logic        mem_read [2], mem_write [2], mem_byte_write [2], mem_busy [2];
  logic [15:0] mem_din [2], mem_dout [2];
`ifdef PSRAM_ARB_STATS_EN
  logic [23:0] stat_a [2], stat_b [2];
  logic [15:0] stat_to [2];
  logic [7:0]  stat_max [2];
`endif

  psram_arbiter #(.FIXED_PRIO(0), .TIMEOUT(31)) dut0 (
    .clk(clk), .reset(rst[0]),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_byte(a_byte[0]), .a_addr(a_addr[0]),
    .a_wdata(a_wdata[0]), .a_rdata(a_rdata[0]), .a_ack(a_ack[0]), .a_err(a_err[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_byte(b_byte[0]), .b_addr(b_addr[0]),
    .b_wdata(b_wdata[0]), .b_rdata(b_rdata[0]), .b_ack(b_ack[0]), .b_err(b_err[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_byte_write(mem_byte_write[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0]), .mem_busy(mem_busy[0])
`ifdef PSRAM_ARB_STATS_EN
    , .stat_a_cnt(stat_a[0]), .stat_b_cnt(stat_b[0]),
    .stat_timeout_cnt(stat_to[0]), .stat_max_wait(stat_max[0])
`endif
  );

  psram_arbiter #(.FIXED_PRIO(1), .TIMEOUT(31)) dut1 (
    .clk(clk), .reset(rst[1]),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_byte(a_byte[1]), .a_addr(a_addr[1]),
    .a_wdata(a_wdata[1]), .a_rdata(a_rdata[1]), .a_ack(a_ack[1]), .a_err(a_err[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_byte(b_byte[1]), .b_addr(b_addr[1]),
    .b_wdata(b_wdata[1]), .b_rdata(b_rdata[1]), .b_ack(b_ack[1]), .b_err(b_err[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_byte_write(mem_byte_write[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1]), .mem_busy(mem_busy[1])
`ifdef PSRAM_ARB_STATS_EN
    , .stat_a_cnt(stat_a[1]), .stat_b_cnt(stat_b[1]),
    .stat_timeout_cnt(stat_to[1]), .stat_max_wait(stat_max[1])
`endif
  );

  // Controller model: busy rises the cycle after a pulse and stays high for
  // busy_len cycles; stuck forces busy high. Read data is latched at the pulse.
  int          busy_len [2];
  logic        stuck [2];
  int          busy_cnt [2];
  int          rd_pulses [2], wr_pulses [2];
  logic [21:0] last_addr [2];
  logic [15:0] last_din [2];
  logic        last_byte [2], last_we [2];
  logic [15:0] dout_q [2];
  logic [15:0] mem_model [2][256];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_busy[i] = stuck[i] || (busy_cnt[i] != 0);
      mem_dout[i] = dout_q[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
      if (mem_read[i] || mem_write[i]) begin
        busy_cnt[i]  <= busy_len[i];
        last_addr[i] <= mem_addr[i];
        last_din[i]  <= mem_din[i];
        last_byte[i] <= mem_byte_write[i];
        last_we[i]   <= mem_write[i];
        if (mem_read[i]) begin
          rd_pulses[i] <= rd_pulses[i] + 1;
          dout_q[i]    <= mem_model[i][mem_addr[i][8:1]];
        end else begin
          wr_pulses[i] <= wr_pulses[i] + 1;
          if (!mem_byte_write[i]) mem_model[i][mem_addr[i][8:1]] <= mem_din[i];
          else if (mem_addr[i][0]) mem_model[i][mem_addr[i][8:1]][15:8] <= mem_din[i][7:0];
          else mem_model[i][mem_addr[i][8:1]][7:0] <= mem_din[i][7:0];
        end
      end
    end
  end

  // Ack counters and a watch for commands issued while the controller is busy.
  int a_acks [2], b_acks [2], viol [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (a_ack[i]) a_acks[i] <= a_acks[i] + 1;
      if (b_ack[i]) b_acks[i] <= b_acks[i] + 1;
      if ((mem_read[i] || mem_write[i]) && mem_busy[i]) viol[i] <= viol[i] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int i, input bit pb, input bit req, input bit we,
                          input bit byt, input logic [21:0] addr, input logic [15:0] wd);
    if (pb) begin
      b_req[i] = req; b_we[i] = we; b_byte[i] = byt; b_addr[i] = addr; b_wdata[i] = wd;
    end else begin
      a_req[i] = req; a_we[i] = we; a_byte[i] = byt; a_addr[i] = addr; a_wdata[i] = wd;
    end
  endtask

  function automatic bit outs_zero(input int i);
    return !mem_read[i] && !mem_write[i] && !mem_byte_write[i] && (mem_addr[i] == 22'd0) &&
           (mem_din[i] == 16'd0) && !a_ack[i] && !b_ack[i] && !a_err[i] && !b_err[i] &&
           (a_rdata[i] == 16'd0) && (b_rdata[i] == 16'd0);
  endfunction

  typedef struct {
    bit          pb;
    bit          we;
    bit          byt;
    logic [21:0] addr;
    logic [15:0] wdata;
    int          busy;
    int          exp_lat;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  int   ord [8];
  int   n, nk, na, pa0, pb0, pr0;
  bit   got, done;

  initial begin
    vecs[0] = '{0, 1, 0, 22'h000010, 16'h1234, 6, 9, 16'h0000};
    vecs[1] = '{0, 0, 0, 22'h000010, 16'h0000, 6, 9, 16'h1234};
    vecs[2] = '{1, 1, 0, 22'h000020, 16'hBEEF, 0, 4, 16'h0000};
    vecs[3] = '{1, 0, 0, 22'h000020, 16'h0000, 2, 5, 16'hBEEF};
    vecs[4] = '{0, 1, 1, 22'h000011, 16'h00AB, 1, 4, 16'h1234};
    vecs[5] = '{0, 0, 0, 22'h000010, 16'h0000, 3, 6, 16'hAB34};
    vecs[6] = '{1, 1, 0, 22'h3FFFFE, 16'h5555, 1, 4, 16'hBEEF};
    vecs[7] = '{1, 0, 0, 22'h3FFFFE, 16'h0000, 4, 7, 16'h5555};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; stuck[i] = 1'b0; busy_len[i] = 0; busy_cnt[i] = 0;
      rd_pulses[i] = 0; wr_pulses[i] = 0; a_acks[i] = 0; b_acks[i] = 0; viol[i] = 0;
      dout_q[i] = 16'd0;
      for (int k = 0; k < 256; k++) mem_model[i][k] = 16'd0;
      set_port(i, 0, 0, 0, 0, 22'd0, 16'd0);
      set_port(i, 1, 0, 0, 0, 22'd0, 16'd0);
    end
    repeat (3) @(negedge clk);
    check("reset_outs_rr", 32'(outs_zero(0)), 32'd1);
    check("reset_outs_fp", 32'(outs_zero(1)), 32'd1);
`ifdef PSRAM_ARB_STATS_EN
    check("reset_stats", {8'd0, stat_a[0]} | {8'd0, stat_b[0]} | {16'd0, stat_to[0]} | {24'd0, stat_max[0]}, 32'd0);
`endif
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // Single-port transactions on the round-robin instance.
    for (int v = 0; v < 8; v++) begin
      pa0 = a_acks[0]; pb0 = b_acks[0];
      busy_len[0] = vecs[v].busy;
      set_port(0, vecs[v].pb, 1, vecs[v].we, vecs[v].byt, vecs[v].addr, vecs[v].wdata);
      n = 0; got = 0;
      while (!got && n < 100) begin
        @(negedge clk); n++;
        got = vecs[v].pb ? b_ack[0] : a_ack[0];
      end
      check($sformatf("vec%0d_latency", v), n, vecs[v].exp_lat);
      check($sformatf("vec%0d_rdata", v), vecs[v].pb ? b_rdata[0] : a_rdata[0], vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), vecs[v].pb ? b_err[0] : a_err[0], 32'd0);
      set_port(0, vecs[v].pb, 0, vecs[v].we, vecs[v].byt, vecs[v].addr, vecs[v].wdata);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_own_acks", v), vecs[v].pb ? b_acks[0] - pb0 : a_acks[0] - pa0, 32'd1);
      check($sformatf("vec%0d_other_acks", v), vecs[v].pb ? a_acks[0] - pa0 : b_acks[0] - pb0, 32'd0);
      check($sformatf("vec%0d_mem_addr", v), last_addr[0], vecs[v].addr);
      check($sformatf("vec%0d_mem_din", v), last_din[0], vecs[v].wdata);
      check($sformatf("vec%0d_byte_we", v), {last_byte[0], last_we[0]}, {vecs[v].byt, vecs[v].we});
    end

    // Round-robin: both held, six grants alternate starting with A.
    busy_len[0] = 1; pr0 = rd_pulses[0] + wr_pulses[0];
    set_port(0, 0, 1, 0, 0, 22'h000010, 16'd0);
    set_port(0, 1, 1, 0, 0, 22'h000020, 16'd0);
    n = 0; nk = 0;
    while (nk < 6 && n < 300) begin
      @(negedge clk); n++;
      if (a_ack[0]) begin ord[nk] = 0; nk++; end
      if (b_ack[0]) begin ord[nk] = 1; nk++; end
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_ack_total", nk, 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("rr_order%0d", k), ord[k], 32'(k % 2));
    check("rr_pulses", rd_pulses[0] + wr_pulses[0] - pr0, 32'd6);

    // Fixed priority: A keeps re-requesting for four ops, B only after A stops.
    busy_len[1] = 1;
    set_port(1, 0, 1, 0, 0, 22'h000010, 16'd0);
    set_port(1, 1, 1, 0, 0, 22'h000020, 16'd0);
    n = 0; nk = 0; na = 0; done = 0;
    while (!done && n < 300) begin
      @(negedge clk); n++;
      if (a_ack[1] && nk < 8) begin ord[nk] = 0; nk++; na++; if (na == 4) a_req[1] = 1'b0; end
      if (b_ack[1] && nk < 8) begin ord[nk] = 1; nk++; b_req[1] = 1'b0; done = 1; end
    end
    repeat (3) @(negedge clk);
    check("fp_ack_total", nk, 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("fp_order%0d", k), ord[k], (k == 4) ? 32'd1 : 32'd0);
    check("fp_pulses", rd_pulses[1] + wr_pulses[1], 32'd5);

    // Timeout: busy never drops, ack with err 31 cycles into WAIT.
    busy_len[0] = 5;
    set_port(0, 0, 1, 0, 0, 22'h000010, 16'd0);
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (n == 2) stuck[0] = 1'b1;
      got = a_ack[0];
    end
    check("timeout_latency", n, 32'd33);
    check("timeout_err", a_err[0], 32'd1);
    a_req[0] = 1'b0;
    @(negedge clk);
    pr0 = rd_pulses[0]; pa0 = a_acks[0];
    a_req[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("stuck_no_issue", rd_pulses[0] - pr0, 32'd0);
    check("stuck_no_ack", a_acks[0] - pa0, 32'd0);
    busy_len[0] = 0; stuck[0] = 1'b0;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      got = a_ack[0];
    end
    check("release_latency", n, 32'd4);
    check("release_err", a_err[0], 32'd0);
    check("release_rdata", a_rdata[0], 32'h0000AB34);
    a_req[0] = 1'b0;
    repeat (3) @(negedge clk);
`ifdef PSRAM_ARB_STATS_EN
    check("stat_a", stat_a[0], 32'd9);
    check("stat_b", stat_b[0], 32'd7);
    check("stat_timeout", stat_to[0], 32'd1);
    check("stat_max_wait", stat_max[0], 32'd31);
    check("stat_fp_a", stat_a[1], 32'd4);
    check("stat_fp_b", stat_b[1], 32'd1);
`endif

    // Reset during WAIT with the controller still busy for five more cycles.
    busy_len[0] = 8; pr0 = rd_pulses[0];
    set_port(0, 0, 1, 0, 0, 22'h000020, 16'd0);
    n = 0;
    while (!mem_read[0] && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    pa0 = a_acks[0];
    rst[0] = 1'b1; busy_len[0] = 0;
    @(negedge clk);
    check("midreset_outs", 32'(outs_zero(0)), 32'd1);
    check("midreset_busy", mem_busy[0], 32'd1);
`ifdef PSRAM_ARB_STATS_EN
    check("midreset_stats", {8'd0, stat_a[0]} | {8'd0, stat_b[0]} | {16'd0, stat_to[0]} | {24'd0, stat_max[0]}, 32'd0);
`endif
    rst[0] = 1'b0;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      got = a_ack[0];
    end
    check("postreset_got_ack", got, 32'd1);
    check("postreset_rdata", a_rdata[0], 32'h0000BEEF);
    a_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("postreset_acks", a_acks[0] - pa0, 32'd1);
    check("postreset_pulses", rd_pulses[0] - pr0, 32'd2);
    check("issue_while_busy_rr", viol[0], 32'd0);
    check("issue_while_busy_fp", viol[1], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
